// File: rtl/fiforr_arb.sv
// fiforr_arb: round-robin burst arbiter draining NREQ FIFO read ports into a
// single registered valid/ready stream. One requester owns the output for a
// whole burst of BLEN words, so input blocks are never interleaved.
// Optional stall watchdog: define FIFORR_ARB_WDOG_EN to build it.
module fiforr_arb #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 32,
  parameter int BLEN  = 17,
  parameter int CNTW  = 5,
  parameter int TMO   = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       fifordy,
  input  logic [NREQ*WIDTH-1:0] fifodout,
  output logic [NREQ-1:0]       fifoget,
  input  logic [NREQ-1:0]       enmask,
  output logic [WIDTH-1:0]      odat,
  output logic                  ovld,
  input  logic                  ordy,
  output logic                  osop,
  output logic                  oeop,
  output logic [IDW-1:0]        oid,
  output logic                  busy,
  output logic                  tmoerr
);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  // Configuration sanity: fail elaboration on an inconsistent parameter set.
  if (NREQ < 2 || NREQ > 8 || BLEN < 2 || BLEN > 31 || (1 << CNTW) < BLEN ||
      IDW != $clog2(NREQ) || TMO < 1 || WIDTH < 1) begin : g_bad_cfg
    $error("fiforr_arb: inconsistent parameters");
  end

  state_t             r_state, w_state_next;
  logic [IDW-1:0]     r_ptr, w_ptr_next;
  logic [IDW-1:0]     r_gnt, w_gnt_next;
  logic [CNTW-1:0]    r_wcnt, w_wcnt_next;
  logic [WIDTH-1:0]   r_odat;
  logic               r_ovld, r_osop, r_oeop;
  logic [IDW-1:0]     r_oid;

  logic [NREQ-1:0]    w_req;
  logic               w_win_vld;
  logic [IDW-1:0]     w_win_idx;
  logic [IDW-1:0]     w_idx;
  logic               w_can_acc;
  logic               w_get;
  logic               w_last;
  logic               w_tmo;
  logic [WIDTH-1:0]   w_din [NREQ];

  assign w_req     = fifordy & enmask;
  assign w_can_acc = !r_ovld || ordy;
  // The consume strobe looks only at the granted FIFO and the output stage.
  assign w_get     = (r_state == S_XFER) && fifordy[r_gnt] && w_can_acc;
  assign w_last    = (r_wcnt == CNTW'(BLEN - 1));

  // Unpack FIFO data lanes and decode the per-FIFO consume strobe.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_din[gi]   = fifodout[gi*WIDTH +: WIDTH];
    assign fifoget[gi] = w_get && (r_gnt == IDW'(gi));
  end

  // Round-robin pick: scan downward so the lowest offset after ptr wins last.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (int'(r_ptr) + k >= NREQ) begin
        w_idx = IDW'(int'(r_ptr) + k - NREQ);
      end else begin
        w_idx = IDW'(int'(r_ptr) + k);
      end
      if (w_req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_idx;
      end
    end
  end

  // Next-state logic: grant in IDLE, count words and close the burst in XFER.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_gnt_next   = r_gnt;
    w_wcnt_next  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_next = S_XFER;
          w_gnt_next   = w_win_idx;
          w_ptr_next   = w_win_idx;
          w_wcnt_next  = '0;
        end
      end
      S_XFER: begin
        if (w_get) begin
          w_wcnt_next = r_wcnt + CNTW'(1);
          if (w_last) begin
            w_state_next = S_IDLE;
          end
        end else if (w_tmo) begin
          // Abandon the stalled burst; ptr already equals gnt.
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register for the arbitration FSM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_ptr   <= IDW'(NREQ - 1);
      r_gnt   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_gnt   <= w_gnt_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // Output register: load on consume, drop valid once accepted with no refill.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_odat <= '0;
      r_ovld <= 1'b0;
      r_osop <= 1'b0;
      r_oeop <= 1'b0;
      r_oid  <= '0;
    end else if (w_get) begin
      r_odat <= w_din[r_gnt];
      r_ovld <= 1'b1;
      r_osop <= (r_wcnt == '0);
      r_oeop <= w_last;
      r_oid  <= r_gnt;
    end else begin
      if (r_ovld && ordy) begin
        r_ovld <= 1'b0;
      end
      if (w_tmo) begin
        r_oid <= r_gnt;
      end
    end
  end

`ifdef FIFORR_ARB_WDOG_EN
  localparam int SW = $clog2(TMO + 1);
  logic [SW-1:0] r_stall;
  logic          r_tmoerr;

  assign w_tmo  = (r_state == S_XFER) && !w_get && (r_stall == SW'(TMO - 1));
  assign tmoerr = r_tmoerr;

  // Stall watchdog: count cycles without a consume while a burst is open.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall  <= '0;
      r_tmoerr <= 1'b0;
    end else begin
      r_tmoerr <= w_tmo;
      if (r_state != S_XFER || w_get || w_tmo) begin
        r_stall <= '0;
      end else begin
        r_stall <= r_stall + SW'(1);
      end
    end
  end
`else
  assign w_tmo  = 1'b0;
  assign tmoerr = 1'b0;
`endif

  assign odat = r_odat;
  assign ovld = r_ovld;
  assign osop = r_osop;
  assign oeop = r_oeop;
  assign oid  = r_oid;
  assign busy = (r_state == S_XFER);

endmodule

// File: tb/tb_fiforr_arb.sv
// Bench for fiforr_arb: directed scenarios push expected words into a
// scoreboard queue; a monitor pops and compares every accepted output word.
module tb_fiforr_arb;
  localparam int NREQ = 4, IDW = 2, WIDTH = 32, BLEN = 17, CNTW = 5, TMO = 255;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NREQ-1:0]       fifordy = '0;
  logic [NREQ*WIDTH-1:0] fifodout;
  logic [NREQ-1:0]       fifoget;
  logic [NREQ-1:0]       enmask = 4'hF;
  logic [WIDTH-1:0]      odat;
  logic                  ovld;
  logic                  ordy = 1'b1;
  logic                  osop, oeop;
  logic [IDW-1:0]        oid;
  logic                  busy, tmoerr;

  fiforr_arb #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .BLEN(BLEN), .CNTW(CNTW), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .fifordy(fifordy), .fifodout(fifodout), .fifoget(fifoget),
    .enmask(enmask), .odat(odat), .ovld(ovld), .ordy(ordy), .osop(osop), .oeop(oeop),
    .oid(oid), .busy(busy), .tmoerr(tmoerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] dat;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [23:0] cnt [NREQ];
  int          tot = 0;
  logic        fifo_clr = 1'b1;
  int          cyc = 0;
  int          last_eop_cyc = -100;

  // FIFO source model: word k of FIFO i is {i, k}; a get advances the FIFO.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
      tot <= 0;
    end else begin
      for (int i = 0; i < NREQ; i++) if (fifoget[i]) cnt[i] <= cnt[i] + 24'd1;
      if (fifoget != '0) tot <= tot + 1;
    end
  end

  always_comb begin
    fifodout = '0;
    for (int i = 0; i < NREQ; i++) fifodout[i*WIDTH +: WIDTH] = {8'(i), cnt[i]};
  end

  task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_burst(input int id, input int start, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id  = 2'(id);
      e.dat = {8'(id), 24'(start + k)};
      e.sop = (k == 0);
      e.eop = (k == BLEN - 1);
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) until FIFO id (or total when id<0) has delivered target words.
  task automatic wait_get(input int id, input int target);
    int k;
    int v;
    v = 0;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      v = (id < 0) ? tot : int'(cnt[id]);
      if (v >= target) break;
    end
    chk("wait_get", v >= target, 64'(v), 64'(target));
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !ovld) break;
    end
    chk("drain", sb.size() == 0 && !ovld, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; fifo_clr = 1'b1; fifordy = '0; enmask = 4'hF; ordy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ovld", ovld == 1'b0, 64'(ovld), 64'd0);
    chk("rst_flags", {osop, oeop, busy, tmoerr} == 4'b0, 64'({osop, oeop, busy, tmoerr}), 64'd0);
    chk("rst_data", odat == '0 && oid == '0, 64'({oid, odat}), 64'd0);
    chk("rst_get", fifoget == '0, 64'(fifoget), 64'd0);
    rstn = 1'b1; fifo_clr = 1'b0;
  endtask

  // Monitor: protocol checks each cycle, scoreboard compare on each accepted word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      chk("get_onehot", $onehot0(fifoget), 64'(fifoget), 64'd0);
      chk("get_rdy", (fifoget & ~fifordy) == '0, 64'(fifoget), 64'(fifordy));
      chk("get_busy", fifoget == '0 || busy, 64'(fifoget), 64'd0);
      if (ovld && ordy) begin
        if (sb.size() == 0) begin
          chk("word_expected", sb.size() != 0, 64'({osop, oeop, oid, odat}), 64'd0);
        end else begin
          e = sb.pop_front();
          $display("word id=%0d dat=%08h sop=%0d eop=%0d exp_id=%0d exp_dat=%08h",
                   oid, odat, osop, oeop, e.id, e.dat);
          chk("word", odat == e.dat && oid == e.id && osop == e.sop && oeop == e.eop,
              64'({osop, oeop, oid, odat}), 64'({e.sop, e.eop, e.id, e.dat}));
        end
        if (osop) chk("burst_gap", cyc - last_eop_cyc >= 2, 64'(cyc - last_eop_cyc), 64'd2);
        if (oeop) last_eop_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Single requester: two back-to-back bursts from FIFO 2, with latency checks.
    do_reset();
    push_burst(2, 0, BLEN);
    push_burst(2, BLEN, BLEN);
    fifordy = 4'b0100;
    #1;
    chk("idle_noget", fifoget == '0, 64'(fifoget), 64'd0);
    @(negedge clk);
    chk("lat_busy", busy == 1'b1 && ovld == 1'b0, 64'({busy, ovld}), 64'b10);
    chk("lat_get", fifoget == 4'b0100, 64'(fifoget), 64'b0100);
    @(negedge clk);
    chk("lat_ovld", ovld == 1'b1 && osop == 1'b1, 64'({ovld, osop}), 64'b11);
    wait_get(2, 2 * BLEN);
    fifordy = '0;
    drain();

    // Round robin over all four requesters from reset priority.
    do_reset();
    push_burst(0, 0, BLEN); push_burst(1, 0, BLEN); push_burst(2, 0, BLEN);
    push_burst(3, 0, BLEN); push_burst(0, BLEN, BLEN);
    fifordy = 4'hF;
    wait_get(-1, 5 * BLEN);
    fifordy = '0;
    drain();

    // Backpressure: ordy low for 3 cycles after word 8 is loaded.
    do_reset();
    push_burst(1, 0, BLEN);
    fifordy = 4'b0010;
    wait_get(1, 8);
    ordy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", ovld == 1'b1 && odat == 32'h0100_0007 && fifoget == '0,
          64'({ovld, fifoget, odat}), 64'({1'b1, 4'b0, 32'h0100_0007}));
      @(posedge clk);
      #1;
    end
    ordy = 1'b1;
    wait_get(1, BLEN);
    fifordy = '0;
    drain();

    // Masking: requester 1 disabled gives 0,2,3,0.
    do_reset();
    enmask = 4'b1101;
    push_burst(0, 0, BLEN); push_burst(2, 0, BLEN); push_burst(3, 0, BLEN);
    push_burst(0, BLEN, BLEN);
    fifordy = 4'hF;
    wait_get(-1, 4 * BLEN);
    fifordy = '0;
    drain();

    // Reset in the middle of a burst from FIFO 2, then requester 0 wins.
    do_reset();
    push_burst(2, 0, 8);
    fifordy = 4'b0100;
    wait_get(2, 8);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out", {ovld, osop, oeop, busy, tmoerr} == 5'b0 && odat == '0 && oid == '0,
        64'({ovld, osop, oeop, busy, tmoerr, oid, odat}), 64'd0);
    chk("midrst_get", fifoget == '0, 64'(fifoget), 64'd0);
    rstn = 1'b1;
    fifordy = 4'hF;
    push_burst(0, 0, BLEN);
    wait_get(0, BLEN);
    fifordy = '0;
    drain();

    // Stall of the granted FIFO after word 5.
    do_reset();
    push_burst(0, 0, 5);
    fifordy = 4'b0001;
    wait_get(0, 5);
    fifordy = '0;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
`ifdef FIFORR_ARB_WDOG_EN
      chk("tmoerr", tmoerr == (k == TMO + 1), 64'(tmoerr), 64'(k == TMO + 1));
      if (k == TMO + 1) begin
        chk("tmo_state", oid == 2'd0 && busy == 1'b0 && oeop == 1'b0,
            64'({oid, busy, oeop}), 64'd0);
      end
`else
      chk("stall_wait", tmoerr == 1'b0 && busy == 1'b1, 64'({tmoerr, busy}), 64'b01);
`endif
    end
`ifdef FIFORR_ARB_WDOG_EN
    push_burst(1, 0, BLEN);
    fifordy = 4'b0011;
    wait_get(1, BLEN);
    fifordy = '0;
`endif
    drain();
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
